// File: rtl/opcodes.sv
// Shared opcode, ALU-function and sequencer-state encodings for the
// multi-cycle control path.
package opcodes;

  localparam int unsigned OPCODE_W = 3;
  localparam int unsigned ALU_FN_W = 2;
  localparam int unsigned STATE_W  = 2;

  typedef enum logic [OPCODE_W-1:0] {
    NOP  = 3'd0,
    ADD  = 3'd1,
    ADDI = 3'd2,
    SUB  = 3'd3,
    MUL  = 3'd4,
    MULI = 3'd5,
    BEQ  = 3'd6,
    IN   = 3'd7
  } opcodes_t;

  typedef enum logic [ALU_FN_W-1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_MUL   = 2'd2,
    ALU_PASSB = 2'd3
  } alu_functions_t;

  typedef enum logic [STATE_W-1:0] {
    RUN    = 2'd0,
    MUL_ST = 2'd1,
    INWAIT = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/cycle_counter.sv
// Loadable down-counter with a combinational zero flag; load wins over
// decrement, and decrement at zero is suppressed so the counter parks there.
module cycle_counter #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic [WIDTH-1:0] o_count,
  output logic             o_zero_c
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_count  = r_count;
  assign o_zero_c = (r_count == '0);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle instruction sequencer: Mealy decode of OpCode in RUN, plus
// multiply sequencing and input-port wait states that freeze the PC.
module multicycle_control
  import opcodes::*;
#(
  parameter int unsigned MUL_CYCLES = 8
) (
  input  logic           Clock,
  input  logic           Reset,
  input  opcodes_t       OpCode,
  input  logic           Cond,
  input  logic           InValid,
  output logic           RegWe,
  output logic           WDataSel,
  output logic           ImmSel,
  output logic           PcWait,
  output logic           PcBranch,
  output logic           MulStart,
  output logic           InAck,
  output alu_functions_t AluOp
);

  localparam int unsigned CNT_W = $clog2(MUL_CYCLES);

  if ((MUL_CYCLES < 2) || (MUL_CYCLES > 64)) begin : g_bad_mul_cycles
    $error("multicycle_control: MUL_CYCLES must be within 2..64");
  end

  ctrl_state_t      r_state;
  ctrl_state_t      w_state_nxt;
  logic             r_mul_imm;
  logic             w_cnt_load;
  logic             w_cnt_dec;
  logic             w_cnt_zero;
  logic [CNT_W-1:0] w_cnt;

  cycle_counter #(
    .WIDTH(CNT_W)
  ) u_cycle_counter (
    .clk       (Clock),
    .rst_n     (Reset),
    .i_load    (w_cnt_load),
    .i_load_val(CNT_W'(MUL_CYCLES - 2)),
    .i_dec     (w_cnt_dec),
    .o_count   (w_cnt),
    .o_zero_c  (w_cnt_zero)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state   <= RUN;
      r_mul_imm <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cnt_load) begin
        r_mul_imm <= (OpCode == MULI);
      end
    end
  end

  // Decode; the Reset gate keeps outputs quiet while reset is asserted.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_load  = 1'b0;
    w_cnt_dec   = 1'b0;
    RegWe       = 1'b0;
    WDataSel    = 1'b0;
    ImmSel      = 1'b0;
    PcWait      = 1'b0;
    PcBranch    = 1'b0;
    MulStart    = 1'b0;
    InAck       = 1'b0;
    AluOp       = ALU_ADD;
    if (Reset) begin
      case (r_state)
        RUN: begin
          case (OpCode)
            ADD: RegWe = 1'b1;
            ADDI: begin
              RegWe  = 1'b1;
              ImmSel = 1'b1;
            end
            SUB: begin
              RegWe = 1'b1;
              AluOp = ALU_SUB;
            end
            BEQ: begin
              AluOp    = ALU_SUB;
              PcBranch = Cond;
            end
            MUL, MULI: begin
              MulStart    = 1'b1;
              PcWait      = 1'b1;
              AluOp       = ALU_MUL;
              ImmSel      = (OpCode == MULI);
              w_cnt_load  = 1'b1;
              w_state_nxt = MUL_ST;
            end
            IN: begin
              if (InValid) begin
                RegWe    = 1'b1;
                WDataSel = 1'b1;
                InAck    = 1'b1;
              end else begin
                PcWait      = 1'b1;
                w_state_nxt = INWAIT;
              end
            end
            default: ;
          endcase
        end
        MUL_ST: begin
          AluOp  = ALU_MUL;
          ImmSel = r_mul_imm;
          if (w_cnt_zero) begin
            RegWe       = 1'b1;
            w_state_nxt = RUN;
          end else begin
            PcWait    = 1'b1;
            w_cnt_dec = 1'b1;
          end
        end
        INWAIT: begin
          if (InValid) begin
            RegWe       = 1'b1;
            WDataSel    = 1'b1;
            InAck       = 1'b1;
            w_state_nxt = RUN;
          end else begin
            PcWait = 1'b1;
          end
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

endmodule
